// File: rtl/vga_pkg.sv
// Shared constants for the VGA capture block: register map, bit positions,
// capture state encoding and the default active geometry of the VGA controller.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [4:0] OFF_CTRL      = 5'h00;
  localparam logic [4:0] OFF_STATUS    = 5'h04;
  localparam logic [4:0] OFF_GEOM      = 5'h08;
  localparam logic [4:0] OFF_CKSUM     = 5'h0C;
  localparam logic [4:0] OFF_PROBE     = 5'h10;
  localparam logic [4:0] OFF_PROBE_PIX = 5'h14;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int GEOM_H_LO = 16;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WAIT_VS  = 2'd1,
    ACTIVE   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/vga_capture_apb_if.sv
// APB register bus of the VGA capture block; master is the CPU side.
interface vga_capture_apb_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable, in_pwrite, in_pwdata,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pwrite, in_pwdata,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/vga_capture_regs.sv
// APB decode, error response and read mux for the VGA capture registers.
// The PROBE/PROBE_PIX pair exists only when VGA_CAPTURE_PROBE_EN is defined.
module vga_capture_regs
  import vga_pkg::*;
(
  vga_capture_apb_if.slave apb,
  input  logic [31:0]      ctrl_word,
  input  logic [31:0]      status_word,
  input  logic [31:0]      geom_word,
  input  logic [31:0]      cksum_word,
`ifdef VGA_CAPTURE_PROBE_EN
  input  logic [31:0]      probe_word,
  input  logic [31:0]      probe_pix_word,
  output logic             probe_wr,
`endif
  output logic             ctrl_wr,
  output logic [31:0]      wdata
);

  logic       access;
  logic [4:0] off;
  logic       rd_ok;
  logic       wr_ok;
  logic [31:0] rdata;
  logic       unused_addr;

  assign access      = apb.in_psel & apb.in_penable;
  assign off         = apb.in_paddr[4:0];
  assign unused_addr = ^apb.in_paddr[31:5];

  always_comb begin
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    rdata = '0;
    case (off)
      OFF_CTRL:      begin rd_ok = 1'b1; wr_ok = 1'b1; rdata = ctrl_word;   end
      OFF_STATUS:    begin rd_ok = 1'b1; rdata = status_word; end
      OFF_GEOM:      begin rd_ok = 1'b1; rdata = geom_word;   end
      OFF_CKSUM:     begin rd_ok = 1'b1; rdata = cksum_word;  end
`ifdef VGA_CAPTURE_PROBE_EN
      OFF_PROBE:     begin rd_ok = 1'b1; wr_ok = 1'b1; rdata = probe_word; end
      OFF_PROBE_PIX: begin rd_ok = 1'b1; rdata = probe_pix_word; end
`endif
      default: ;
    endcase
  end

  // Zero-wait slave: every access phase completes in the cycle it is presented.
  assign apb.in_pready  = access;
  assign apb.in_prdata  = access ? rdata : '0;
  assign apb.in_pslverr = access & (apb.in_pwrite ? ~wr_ok : ~rd_ok);

  assign ctrl_wr = access & apb.in_pwrite & (off == OFF_CTRL);
  assign wdata   = apb.in_pwdata;
`ifdef VGA_CAPTURE_PROBE_EN
  assign probe_wr = access & apb.in_pwrite & (off == OFF_PROBE);
`endif

endmodule

// File: rtl/vga_capture_apb.sv
// VGA sink and frame checker: counts geometry and a pixel checksum per frame.
// Optional pixel probe registers are built when VGA_CAPTURE_PROBE_EN is defined.
module vga_capture_apb
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       vga_r,
  input  logic [7:0]       vga_g,
  input  logic [7:0]       vga_b,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  input  logic             vga_valid,
  vga_capture_apb_if.slave apb,
  output logic             frame_done
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t H_EXP = cnt_t'(H_ACTIVE);
  localparam cnt_t V_EXP = cnt_t'(V_ACTIVE);

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  cap_state_e  state_q, state_d;
  logic        hs_prev, vs_prev, hs_fall, vs_fall;
  cnt_t        x_q, y_q, lastx_q, width_q, height_q;
  cnt_t        x_inc, x_line, y_line, lastx_line;
  logic [31:0] sum_q, sum_inc, cksum_q, pix;
  logic [15:0] frames_q;
  logic        en_q, locked_q, err_hw_q, err_vh_q, ferr_q;
  logic        line_close, hw_err, vh_err, frame_close, clr_work;
  logic        ctrl_wr;
  logic [31:0] wdata;
  logic        unused_wdata;

  assign pix          = {8'h0, vga_r, vga_g, vga_b};
  assign hs_fall      = hs_prev & ~vga_hsync;
  assign vs_fall      = vs_prev & ~vga_vsync;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clock) begin
    if (reset) state_q <= DISABLED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: if (ctrl_wr && wdata[CTRL_EN]) state_d = WAIT_VS;
      WAIT_VS:  if (vs_fall) state_d = ACTIVE;
      default:  ;
    endcase
    if (ctrl_wr && !wdata[CTRL_EN]) state_d = DISABLED;
  end

  // Line close sees this cycle's pixel; frame close sees this cycle's line close.
  always_comb begin
    x_inc       = vga_valid ? sat_inc(x_q) : x_q;
    sum_inc     = vga_valid ? sum_q + pix : sum_q;
    line_close  = hs_fall && (x_inc != '0);
    hw_err      = (state_q == ACTIVE) && line_close && (x_inc != H_EXP);
    y_line      = line_close ? sat_inc(y_q) : y_q;
    x_line      = line_close ? '0 : x_inc;
    lastx_line  = (x_inc != '0) ? x_inc : lastx_q;
    frame_close = (state_q == ACTIVE) && vs_fall;
    vh_err      = y_line != V_EXP;
    clr_work    = ((state_q == WAIT_VS) && vs_fall) || frame_close ||
                  (ctrl_wr && !wdata[CTRL_EN]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_prev <= 1'b0; vs_prev <= 1'b0; frame_done <= 1'b0;
      x_q <= '0; y_q <= '0; lastx_q <= '0; sum_q <= '0; ferr_q <= 1'b0;
      width_q <= '0; height_q <= '0; cksum_q <= '0; frames_q <= '0;
      en_q <= 1'b0; locked_q <= 1'b0; err_hw_q <= 1'b0; err_vh_q <= 1'b0;
    end else begin
      hs_prev    <= vga_hsync;
      vs_prev    <= vga_vsync;
      frame_done <= frame_close;
      if (ctrl_wr) en_q <= wdata[CTRL_EN];
      if (hw_err) err_hw_q <= 1'b1;
      if (frame_close) begin
        width_q  <= lastx_line;
        height_q <= y_line;
        cksum_q  <= sum_inc;
        frames_q <= frames_q + 16'd1;
        if (vh_err) err_vh_q <= 1'b1;
        locked_q <= !(ferr_q || hw_err || vh_err);
      end
      if (clr_work) begin
        x_q <= '0; y_q <= '0; lastx_q <= '0; sum_q <= '0; ferr_q <= 1'b0;
      end else if (state_q == ACTIVE) begin
        x_q <= x_line; y_q <= y_line; lastx_q <= lastx_line; sum_q <= sum_inc;
        ferr_q <= ferr_q | hw_err;
      end
      if (ctrl_wr && wdata[CTRL_CLR]) begin
        err_hw_q <= 1'b0; err_vh_q <= 1'b0; locked_q <= 1'b0;
      end
    end
  end

`ifdef VGA_CAPTURE_PROBE_EN
  cnt_t        px_q, py_q;
  logic [31:0] probe_pix_q;
  logic        probe_wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      px_q <= '0; py_q <= '0; probe_pix_q <= '0;
    end else begin
      if (probe_wr) begin
        px_q <= wdata[CNT_W-1:0];
        py_q <= wdata[GEOM_H_LO +: CNT_W];
      end
      if ((state_q == ACTIVE) && vga_valid && (x_q == px_q) && (y_q == py_q))
        probe_pix_q <= pix;
    end
  end
`endif

  vga_capture_regs u_regs (
    .apb           (apb),
    .ctrl_word     ({30'h0, 1'b0, en_q}),
    .status_word   ({frames_q, 12'h0, state_q == ACTIVE, err_vh_q, err_hw_q, locked_q}),
    .geom_word     (32'(width_q) | (32'(height_q) << GEOM_H_LO)),
    .cksum_word    (cksum_q),
`ifdef VGA_CAPTURE_PROBE_EN
    .probe_word    (32'(px_q) | (32'(py_q) << GEOM_H_LO)),
    .probe_pix_word(probe_pix_q),
    .probe_wr      (probe_wr),
`endif
    .ctrl_wr       (ctrl_wr),
    .wdata         (wdata)
  );

endmodule

// File: tb/tb_vga_capture_apb.sv
// Directed/randomized bench for vga_capture_apb with a frame-level reference model.
module tb_vga_capture_apb;

  localparam int H = 32;
  localparam int V = 24;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_valid;
  logic       frame_done;

  vga_capture_apb_if apb_bus ();

  vga_capture_apb #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(11)) dut (
    .clock      (clock),
    .reset      (reset),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_valid  (vga_valid),
    .apb        (apb_bus),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  always @(posedge clock) if (frame_done === 1'b1) fd_cnt++;

  // Reference model state: what the registers should hold after each frame.
  logic [15:0] m_frames;
  logic        m_locked, m_hw, m_vh, m_active;
  logic [31:0] m_w, m_h, m_ck, m_sum;
  int          m_line;

  task automatic model_reset();
    m_frames = '0; m_locked = 0; m_hw = 0; m_vh = 0; m_active = 0;
    m_w = '0; m_h = '0; m_ck = '0; m_sum = '0; m_line = 0;
  endtask

  function automatic logic [31:0] status_exp();
    return {m_frames, 12'h0, m_active, m_vh, m_hw, m_locked};
  endfunction

  function automatic logic [31:0] pix_at(input int mode, input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    case (mode)
      0:       return 32'h0000_0001;
      1:       return {8'h0, 24'($urandom)};
      default: return {8'h0, xb, yb, xb + yb};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] d, output logic e, output logic r);
    apb_bus.in_paddr   = a;
    apb_bus.in_pwrite  = wr;
    apb_bus.in_pwdata  = wd;
    apb_bus.in_psel    = 1'b1;
    apb_bus.in_penable = 1'b0;
    tick();
    apb_bus.in_penable = 1'b1;
    #1;
    d = apb_bus.in_prdata;
    e = apb_bus.in_pslverr;
    r = apb_bus.in_pready;
    tick();
    apb_bus.in_psel    = 1'b0;
    apb_bus.in_penable = 1'b0;
    apb_bus.in_pwrite  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e, r;
    apb_xfer(a, 1'b0, 32'h0, d, e, r);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, output logic e);
    logic [31:0] d;
    logic r;
    apb_xfer(a, 1'b1, wd, d, e, r);
  endtask

  task automatic vsync_pulse();
    vga_vsync = 1'b0; tick(); tick();
    vga_vsync = 1'b1; tick(); tick();
  endtask

  task automatic send_line(input int w, input int mode);
    logic [31:0] p;
    for (int i = 0; i < w; i++) begin
      p = pix_at(mode, i, m_line);
      {vga_r, vga_g, vga_b} = p[23:0];
      vga_valid = 1'b1;
      m_sum += p;
      tick();
    end
    vga_valid = 1'b0;
    {vga_r, vga_g, vga_b} = 24'h0;
    tick(); tick();
    vga_hsync = 1'b0; tick(); tick();
    vga_hsync = 1'b1; tick();
    m_line++;
  endtask

  // One frame of nlines lines (line short_idx is one pixel short), closed by a vsync pulse.
  task automatic send_frame(input int nlines, input int short_idx, input int mode, input bit counted);
    int  w, lastw;
    bit  hw_new, vh_new;
    m_sum = '0; m_line = 0; lastw = 0; hw_new = 0;
    for (int l = 0; l < nlines; l++) begin
      w = (l == short_idx) ? H - 1 : H;
      if (w != H) hw_new = 1;
      send_line(w, mode);
      lastw = w;
    end
    vsync_pulse();
    if (counted) begin
      vh_new   = (nlines != V);
      m_frames = m_frames + 16'd1;
      m_w      = 32'(lastw);
      m_h      = 32'(nlines);
      m_ck     = m_sum;
      m_hw     = m_hw | hw_new;
      m_vh     = m_vh | vh_new;
      m_locked = !(hw_new || vh_new);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e, r;
    int          fd0;

    reset = 1'b1;
    vga_r = 0; vga_g = 0; vga_b = 0;
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_valid = 1'b0;
    apb_bus.in_paddr = '0; apb_bus.in_psel = 0; apb_bus.in_penable = 0;
    apb_bus.in_pwrite = 0; apb_bus.in_pwdata = '0;
    model_reset();
    tick(); tick(); tick();
    check("reset_frame_done", {31'h0, frame_done}, 32'h0);
    check("reset_pready_idle", {31'h0, apb_bus.in_pready}, 32'h0);
    reset = 1'b0;
    tick();

    apb_xfer(32'h04, 1'b0, 32'h0, d, e, r);
    check("reset_status", d, 32'h0);
    check("reset_pready", {31'h0, r}, 32'h1);
    check("reset_pslverr", {31'h0, e}, 32'h0);
    rd_check("reset_geom", 32'h08, 32'h0);

    // Two clean frames of a constant pixel.
    wr(32'h00, 32'h1, e);
    fd0 = fd_cnt;
    vsync_pulse();
    m_active = 1;
    send_frame(V, -1, 0, 1);
    send_frame(V, -1, 0, 1);
    check("two_frames_done", 32'(fd_cnt - fd0), 32'd2);
    rd_check("clean_geom", 32'h08, (m_h << 16) | m_w);
    rd_check("clean_cksum", 32'h0C, 32'(H * V));
    rd_check("clean_status", 32'h04, status_exp());

    // Random pixels with one short line.
    send_frame(V, 5, 1, 1);
    rd_check("hwidth_status", 32'h04, status_exp());
    rd_check("hwidth_cksum", 32'h0C, m_ck);
    rd_check("hwidth_geom", 32'h08, (m_h << 16) | m_w);

    // Clear errors, then a clean random frame relocks.
    wr(32'h00, 32'h3, e);
    m_hw = 0; m_vh = 0; m_locked = 0;
    rd_check("clr_status", 32'h04, status_exp());
    send_frame(V, -1, 1, 1);
    apb_xfer(32'h04, 1'b0, 32'h0, d, e, r);
    check("relock_bits", d & 32'h7, 32'h1);
    rd_check("relock_cksum", 32'h0C, m_ck);

    // One line short in height.
    send_frame(V - 1, -1, 1, 1);
    rd_check("vheight_status", 32'h04, status_exp());
    rd_check("vheight_geom", 32'h08, (m_h << 16) | m_w);

    // Disabled capture ignores the stream.
    wr(32'h00, 32'h0, e);
    m_active = 0;
    fd0 = fd_cnt;
    vsync_pulse();
    send_frame(V, -1, 1, 0);
    check("disabled_no_done", 32'(fd_cnt - fd0), 32'd0);
    rd_check("disabled_status", 32'h04, status_exp());
    rd_check("ctrl_readback", 32'h00, 32'h0);

    // Error responses.
    wr(32'h0C, 32'hDEAD_BEEF, e);
    check("wr_ro_pslverr", {31'h0, e}, 32'h1);
    rd_check("wr_ro_cksum_kept", 32'h0C, m_ck);
    wr(32'h04, 32'hFFFF_FFFF, e);
    check("wr_status_pslverr", {31'h0, e}, 32'h1);
    rd_check("wr_status_kept", 32'h04, status_exp());
    apb_xfer(32'h1C, 1'b0, 32'h0, d, e, r);
    check("rd_unmapped_pslverr", {31'h0, e}, 32'h1);
    check("rd_unmapped_prdata", d, 32'h0);
    apb_xfer(32'h10, 1'b0, 32'h0, d, e, r);
`ifdef VGA_CAPTURE_PROBE_EN
    check("rd_probe_pslverr", {31'h0, e}, 32'h0);
`else
    check("rd_probe_pslverr", {31'h0, e}, 32'h1);
`endif

    // Reset part way through a frame.
    wr(32'h00, 32'h1, e);
    vsync_pulse();
    m_sum = '0; m_line = 0;
    for (int l = 0; l < 10; l++) send_line(H, 0);
    vga_valid = 1'b1; {vga_r, vga_g, vga_b} = 24'h123456;
    tick(); tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vga_valid = 1'b0; {vga_r, vga_g, vga_b} = 24'h0;
    tick();
    model_reset();
    rd_check("midreset_status", 32'h04, 32'h0);
    rd_check("midreset_geom", 32'h08, 32'h0);
    rd_check("midreset_cksum", 32'h0C, 32'h0);
    wr(32'h00, 32'h1, e);
    fd0 = fd_cnt;
    vsync_pulse();
    m_active = 1;
    send_frame(V, -1, 1, 1);
    check("midreset_one_done", 32'(fd_cnt - fd0), 32'd1);
    rd_check("midreset_geom_after", 32'h08, (32'(V) << 16) | 32'(H));
    rd_check("midreset_status_after", 32'h04, status_exp());

`ifdef VGA_CAPTURE_PROBE_EN
    wr(32'h10, (32'd20 << 16) | 32'd10, e);
    rd_check("probe_readback", 32'h10, (32'd20 << 16) | 32'd10);
    send_frame(V, -1, 2, 1);
    rd_check("probe_pix", 32'h14, pix_at(2, 10, 20));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture_apb.md
Name: vga_capture_apb

Overview:
- VGA sink and frame checker: samples the pixel/sync stream produced by the VGA controller and reconstructs frame geometry and a pixel checksum.
- Results are exposed as a small APB register slave.
- Used in SoC simulation and FPGA self-test to confirm the framebuffer path end to end, i.e. that the pixels written over APB come back out of the VGA port.

Parameters:
- H_ACTIVE, 640, expected valid pixels per line
- V_ACTIVE, 480, expected valid lines per frame
- CNT_W, 11, width of the x/y counters; saturate at all-ones

Ports:
- clock  in  1  system clock; VGA stream sampled on the same clock
- reset  in  1  synchronous, active-high
- vga_r  in  8  red
- vga_g  in  8  green
- vga_b  in  8  blue
- vga_hsync  in  1  active-low line sync
- vga_vsync  in  1  active-low frame sync
- vga_valid  in  1  pixel valid (blanking when 0)
- in_paddr  in  32  APB address; only [4:0] decoded
- in_psel  in  1  APB select
- in_penable  in  1  APB enable
- in_pwrite  in  1  APB write
- in_pwdata  in  32  APB write data
- in_pready  out  1  APB ready
- in_prdata  out  32  APB read data
- in_pslverr  out  1  APB error
- frame_done  out  1  one-cycle pulse when a frame's results are latched

Behaviour:
- Reset values:
  - in_pready=0, in_prdata=0, in_pslverr=0, frame_done=0
  - all registers 0; state DISABLED
- Sync edges: register hsync and vsync once; an edge is prev=1, cur=0. The RGB/valid inputs are not delayed.
- State DISABLED: no counting. Leave when CTRL.en is written to 1 -> WAIT_VS.
- State WAIT_VS: wait for a vsync falling edge -> ACTIVE. Clear the working counters x, y, line_had_px and sum.
- State ACTIVE, per cycle:
  - if vga_valid: x+=1 and sum+=({8'h0,r,g,b}) mod 2^32
  - on an hsync falling edge with x!=0: if x!=H_ACTIVE set ERR.hwidth; y+=1; x=0
  - on an hsync falling edge with x==0: nothing
- End of frame (vsync falling edge while in ACTIVE):
  - latch WIDTH=last nonzero x, HEIGHT=y, CHECKSUM=sum
  - FRAMES+=1 (16-bit, wraps)
  - if y!=V_ACTIVE set ERR.vheight
  - LOCKED=1 iff this frame raised no new error
  - pulse frame_done for 1 cycle; clear working counters; stay ACTIVE
- A vsync edge and an hsync edge in the same cycle: process the line close first, then the frame close.
- Writing CTRL.en=0 in any state -> DISABLED next cycle. Latched registers are kept; working counters are discarded.
- Counters saturate at 2^CNT_W-1; no wrap.
- APB:
  - zero-wait: in_pready = psel & penable
  - in_prdata is combinational in the access phase, 0 otherwise
  - writes take effect on the access-phase edge
- Register map (offsets):
  - 0x00 CTRL RW: [0] en, [1] clr_err (write-1 self-clearing; clears ERR and LOCKED)
  - 0x04 STATUS RO: [0] LOCKED, [1] ERR.hwidth, [2] ERR.vheight, [3] active, [31:16] FRAMES
  - 0x08 GEOM RO: [10:0] WIDTH, [26:16] HEIGHT
  - 0x0C CHECKSUM RO
- in_pslverr=1 in the access phase for a write to an RO or unmapped offset, or a read of an unmapped offset. Such a write has no effect.
- Reset mid-frame returns everything to the reset values; no partial results are latched.

Optional Feature:
- Macro VGA_CAPTURE_PROBE_EN adds:
  - 0x10 PROBE RW: [10:0] px, [26:16] py
  - 0x14 PROBE_PIX RO: {8'h0,r,g,b}
- In ACTIVE, PROBE_PIX updates when vga_valid && x==px && y==py, with x and y taken before the increment.
- Without the macro, 0x10 and 0x14 are unmapped and give pslverr.

Decomposition:
- Shared package vga_pkg:
  - register offsets and bit positions
  - state enum (DISABLED, WAIT_VS, ACTIVE)
  - default H_ACTIVE/V_ACTIVE, the same constants used by the VGA controller
- One natural sub-module, vga_capture_regs: APB decode, pslverr and the register read mux. The capture datapath stays in the top.

Test Plan:
- Reset, then read 0x04 and 0x08 -> both 0; pready=1 in the access phase; pslverr=0.
- Enable, drive two 640x480 frames of pixel 0x000001 -> frame_done pulses twice; GEOM=0x01E0_0280; CHECKSUM=0x0004_B000; STATUS=0x0002_0009.
- One line with 639 valid pixels -> ERR.hwidth=1, LOCKED=0. Then write clr_err and send a clean frame -> STATUS[2:0]=3'b001.
- Frame with 479 lines -> ERR.vheight=1, HEIGHT=479. Drive a stream while en=0 -> FRAMES unchanged, no frame_done.
- Write 0x0C -> pslverr=1, CHECKSUM unchanged. Read 0x1C -> pslverr=1, prdata=0.
- Assert reset at line 200 mid-frame, then re-enable and send a full frame -> exactly one frame_done, GEOM=0x01E0_0280. With VGA_CAPTURE_PROBE_EN, PROBE=(10,20) on a gradient image -> PROBE_PIX matches the model.
